dmem_arbiter: RTL and testbench

Single-port data-RAM arbiter and sequencer between the Hack CPU data port and one external requester (display scanner / DMA loader). Converts the CPU's same-cycle memory read into a one-stall-cycle access against a synchronous RAM, and generates the CPU `stall`. It also grants the external port single-word accesses under a bounded-priority rule. Sits between the CPU, the data RAM and the video/DMA block in the top level.

---
 rtl/dmem_arbiter_if.sv | 43 ++++
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU data port, the external requester port and the data RAM port.
// The arbiter takes the slave view; the CPU/external block/RAM side takes the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  cpu_rd_req;
    logic                  cpu_wr_req;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [15:0]           cpu_wdata;
    logic [15:0]           cpu_rdata;
    logic                  cpu_stall;

    logic                  ext_req;
    logic                  ext_we;
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic [15:0]           ext_wdata;
    logic                  ext_gnt;
    logic                  ext_rvalid;
    logic [15:0]           ext_rdata;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [15:0]           ram_wdata;
    logic [15:0]           ram_rdata;

    modport slave (
        input  cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_rd_req, cpu_wr_req, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-RAM arbiter/sequencer for the Hack CPU data port and one external requester.
// Define DMEM_ARB_FAIRNESS_EN to bound consecutive external grants while the CPU waits.
module dmem_arbiter #(
    parameter int ADDR_WIDTH    = 15,
    parameter int EXT_MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          resetN,
    dmem_arbiter_if.slave bus
);
    // state  | meaning
    // IDLE   | arbitrate: external access, CPU write, or CPU read address phase
    // CPU_RD | CPU read data phase; optional write-back of the modified value
    typedef enum logic {
        IDLE   = 1'b0,
        CPU_RD = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic                  cpu_req;
    logic                  ext_allowed;
    logic                  ext_win;
    logic                  ext_rvalid_q;
    logic [ADDR_WIDTH-1:0] ram_addr_d;
    logic                  ram_we_d;
    logic [15:0]           ram_wdata_d;
    logic                  stall_d;
    logic                  gnt_d;

    if (EXT_MAX_BURST < 1 || EXT_MAX_BURST > 255) begin : g_bad_burst
        $error("EXT_MAX_BURST must be in 1..255");
    end

    assign cpu_req = bus.cpu_rd_req | bus.cpu_wr_req;
    assign ext_win = (state == IDLE) && bus.ext_req && ext_allowed;

`ifdef DMEM_ARB_FAIRNESS_EN
    logic [7:0] starve_cnt;

    // Counts external grants taken while the CPU was waiting; cleared when the CPU wins.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            starve_cnt <= '0;
        end else if (ext_win && cpu_req) begin
            if (starve_cnt != 8'hFF) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end else if (state == IDLE && cpu_req) begin
            starve_cnt <= '0;
        end
    end

    assign ext_allowed = starve_cnt < 8'(EXT_MAX_BURST);
`else
    assign ext_allowed = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state        <= IDLE;
            ext_rvalid_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            ext_rvalid_q <= gnt_d & ~bus.ext_we;
        end
    end

    always_comb begin
        state_nxt   = state;
        ram_addr_d  = bus.cpu_addr;
        ram_we_d    = 1'b0;
        ram_wdata_d = bus.cpu_wdata;
        stall_d     = 1'b0;
        gnt_d       = 1'b0;
        case (state)
            IDLE: begin
                if (ext_win) begin
                    ram_addr_d  = bus.ext_addr;
                    ram_we_d    = bus.ext_we;
                    ram_wdata_d = bus.ext_wdata;
                    gnt_d       = 1'b1;
                    stall_d     = cpu_req;
                end else if (bus.cpu_rd_req) begin
                    stall_d   = 1'b1;
                    state_nxt = CPU_RD;
                end else if (bus.cpu_wr_req) begin
                    ram_we_d = 1'b1;
                end
            end
            CPU_RD: begin
                // Store in the data phase covers read-modify-write such as M=M+1.
                ram_we_d  = bus.cpu_wr_req;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!resetN) begin
            ram_we_d  = 1'b0;
            stall_d   = 1'b0;
            gnt_d     = 1'b0;
            state_nxt = IDLE;
        end
    end

    assign bus.ram_addr   = ram_addr_d;
    assign bus.ram_we     = ram_we_d;
    assign bus.ram_wdata  = ram_wdata_d;
    assign bus.cpu_stall  = stall_d;
    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.ext_gnt    = gnt_d;
    assign bus.ext_rvalid = ext_rvalid_q;
    assign bus.ext_rdata  = bus.ram_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level model with a shadow memory.
module tb_dmem_arbiter;
    localparam int AW   = 15;
    localparam int MAXB = 8;
`ifdef DMEM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
    dmem_arbiter #(.ADDR_WIDTH(AW), .EXT_MAX_BURST(MAXB)) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    // Synchronous RAM with a backdoor preload port
    logic [15:0]   mem [0:(1<<AW)-1];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [15:0]   bd_data = '0;
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [15:0] wd,
                         input logic er, input logic ew, input logic [AW-1:0] ea, input logic [15:0] ewd);
        bus.cpu_rd_req = rd; bus.cpu_wr_req = wr; bus.cpu_addr = a; bus.cpu_wdata = wd;
        bus.ext_req = er; bus.ext_we = ew; bus.ext_addr = ea; bus.ext_wdata = ewd;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Leaves the bench at a negedge with reset released and the arbiter idle.
    task automatic reset_pulse();
        @(negedge clk);
        resetN = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    typedef struct {
        logic rd, wr; logic [AW-1:0] addr; logic [15:0] wd;
        logic er, ew; logic [AW-1:0] eaddr; logic [15:0] ewd;
        logic x_stall, x_gnt, x_we; logic [AW-1:0] x_addr; logic [15:0] x_wd;
    } vec_t;
    vec_t vecs [7];

    // Random-run model state
    logic [15:0]   ref_mem [0:15];
    bit            cpu_busy, ext_busy, c_rd, c_wr, e_we;
    logic [AW-1:0] c_addr, e_addr;
    logic [15:0]   c_wd, e_wd, m_cpu_data, m_rdata, nx_rdata;
    bit            m_second, m_rvalid, nx_rvalid, exp_gnt, exp_stall, cpu_done;
    int            m_starve;

    initial begin
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        // Reset-state checks with requests present
        @(negedge clk);
        drive(1, 1, 15'h0005, 16'h0001, 1, 1, 15'h0006, 16'h0002);
        #1;
        chk("rst_stall", bus.cpu_stall, 0);
        chk("rst_gnt", bus.ext_gnt, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_rvalid", bus.ext_rvalid, 0);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        preload(15'h0010, 16'h1234);
        preload(15'h0020, 16'h0005);
        preload(15'h4000, 16'h00AA);
        preload(15'h0040, 16'h0001);

        // rd wr addr wd | er ew eaddr ewd | stall gnt we addr wd
        vecs[0] = '{0,0,15'h0123,16'h0000, 0,0,15'h0000,16'h0000, 0,0,0,15'h0123,16'h0000};
        vecs[1] = '{1,0,15'h0010,16'h0000, 0,0,15'h0000,16'h0000, 1,0,0,15'h0010,16'h0000};
        vecs[2] = '{0,1,15'h7FFF,16'hBEEF, 0,0,15'h0000,16'h0000, 0,0,1,15'h7FFF,16'hBEEF};
        vecs[3] = '{1,1,15'h0020,16'h0006, 0,0,15'h0000,16'h0000, 1,0,0,15'h0020,16'h0000};
        vecs[4] = '{0,0,15'h0001,16'h0000, 1,0,15'h4000,16'h0000, 0,1,0,15'h4000,16'h0000};
        vecs[5] = '{0,1,15'h2222,16'h3333, 1,1,15'h1111,16'hC0DE, 1,1,1,15'h1111,16'hC0DE};
        vecs[6] = '{1,0,15'h0010,16'h0000, 1,0,15'h4000,16'h0000, 1,1,0,15'h4000,16'h0000};
        for (int i = 0; i < 7; i++) begin
            reset_pulse();
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                  vecs[i].er, vecs[i].ew, vecs[i].eaddr, vecs[i].ewd);
            #1;
            chk($sformatf("vec%0d_stall", i), bus.cpu_stall, vecs[i].x_stall);
            chk($sformatf("vec%0d_gnt", i), bus.ext_gnt, vecs[i].x_gnt);
            chk($sformatf("vec%0d_we", i), bus.ram_we, vecs[i].x_we);
            chk($sformatf("vec%0d_addr", i), bus.ram_addr, vecs[i].x_addr);
            if (vecs[i].x_we) chk($sformatf("vec%0d_wdata", i), bus.ram_wdata, vecs[i].x_wd);
        end

        // CPU read
        reset_pulse();
        drive(1, 0, 15'h0010, 16'h0000, 0, 0, '0, '0);
        #1 chk("rd_stall1", bus.cpu_stall, 1);
        @(negedge clk); #1;
        chk("rd_stall2", bus.cpu_stall, 0);
        chk("rd_data", bus.cpu_rdata, 16'h1234);
        chk("rd_we2", bus.ram_we, 0);

        // Read-modify-write
        reset_pulse();
        drive(1, 1, 15'h0020, 16'h0000, 0, 0, '0, '0);
        #1 chk("rmw_stall1", bus.cpu_stall, 1);
        chk("rmw_we1", bus.ram_we, 0);
        @(negedge clk);
        bus.cpu_wdata = 16'h0006;
        #1;
        chk("rmw_stall2", bus.cpu_stall, 0);
        chk("rmw_rdata", bus.cpu_rdata, 16'h0005);
        chk("rmw_we2", bus.ram_we, 1);
        chk("rmw_addr2", bus.ram_addr, 15'h0020);
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        chk("rmw_mem", mem[15'h0020], 16'h0006);

        // Write only
        reset_pulse();
        drive(0, 1, 15'h7FFF, 16'hBEEF, 0, 0, '0, '0);
        #1 chk("wr_stall", bus.cpu_stall, 0);
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        chk("wr_mem", mem[15'h7FFF], 16'hBEEF);

        // Collision: external read against CPU write
        reset_pulse();
        drive(0, 1, 15'h0030, 16'h5555, 1, 0, 15'h4000, 16'h0000);
        #1;
        chk("col_gnt1", bus.ext_gnt, 1);
        chk("col_stall1", bus.cpu_stall, 1);
        @(negedge clk);
        bus.ext_req = 1'b0;
        #1;
        chk("col_rvalid", bus.ext_rvalid, 1);
        chk("col_rdata", bus.ext_rdata, 16'h00AA);
        chk("col_stall2", bus.cpu_stall, 0);
        chk("col_we2", bus.ram_we, 1);
        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        chk("col_mem", mem[15'h0030], 16'h5555);

        // Held external stream against a CPU read
        reset_pulse();
        drive(1, 0, 15'h0010, 16'h0000, 1, 0, 15'h0100, 16'h0000);
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) @(negedge clk);
            if (FAIR && c == 11) bus.cpu_rd_req = 1'b0;
            #1;
            if (FAIR) begin
                chk($sformatf("fair_gnt_c%0d", c), bus.ext_gnt, (c <= MAXB || c == 11) ? 1 : 0);
                chk($sformatf("fair_stall_c%0d", c), bus.cpu_stall, (c <= MAXB + 1) ? 1 : 0);
                if (c == MAXB + 2) chk("fair_rdata", bus.cpu_rdata, 16'h1234);
            end else begin
                chk($sformatf("strict_gnt_c%0d", c), bus.ext_gnt, 1);
                chk($sformatf("strict_stall_c%0d", c), bus.cpu_stall, 1);
            end
        end

        // Reset during the read data phase suppresses the pending write
        reset_pulse();
        drive(0, 0, '0, '0, 1, 0, 15'h4000, 16'h0000);
        #1 chk("rr_gnt", bus.ext_gnt, 1);
        @(negedge clk);
        drive(1, 1, 15'h0040, 16'h7777, 0, 0, '0, '0);
        #1;
        chk("rr_stall1", bus.cpu_stall, 1);
        chk("rr_rvalid1", bus.ext_rvalid, 1);
        @(negedge clk);
        resetN = 1'b0;
        bus.ext_req = 1'b1;
        #1;
        chk("rr_we_rst", bus.ram_we, 0);
        chk("rr_stall_rst", bus.cpu_stall, 0);
        chk("rr_gnt_rst", bus.ext_gnt, 0);
        @(negedge clk);
        resetN = 1'b1;
        drive(1, 0, 15'h0040, 16'h0000, 0, 0, '0, '0);
        #1;
        chk("rr_mem", mem[15'h0040], 16'h0001);
        chk("rr_idle_stall", bus.cpu_stall, 1);
        chk("rr_rvalid2", bus.ext_rvalid, 0);
        @(negedge clk); #1;
        chk("rr_rdata", bus.cpu_rdata, 16'h0001);

        // Randomized run against the shadow-memory model
        @(negedge clk);
        resetN = 1'b0;
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = 16'($urandom);
            preload(AW'(a), ref_mem[a]);
        end
        cpu_busy = 0; ext_busy = 0; m_second = 0; m_rvalid = 0; m_starve = 0;
        c_rd = 0; c_wr = 0; e_we = 0; c_addr = '0; e_addr = '0; c_wd = '0; e_wd = '0;
        m_rdata = '0; m_cpu_data = '0;
        @(negedge clk);
        resetN = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (!cpu_busy) begin
                c_rd = 1'($urandom_range(0, 1));
                c_wr = 1'($urandom_range(0, 1));
                c_addr = AW'($urandom_range(0, 15));
                c_wd = 16'($urandom);
                cpu_busy = c_rd | c_wr;
            end
            if (!ext_busy) begin
                if ($urandom_range(0, 2) == 0) begin
                    ext_busy = 1;
                    e_we = 1'($urandom_range(0, 1));
                    e_addr = AW'($urandom_range(0, 15));
                    e_wd = 16'($urandom);
                end
            end else if ($urandom_range(0, 15) == 0) begin
                ext_busy = 0;
            end
            drive(cpu_busy & c_rd, cpu_busy & c_wr, c_addr, c_wd, ext_busy, e_we, e_addr, e_wd);

            exp_gnt = 0; exp_stall = 0; cpu_done = 0; nx_rvalid = 0; nx_rdata = '0;
            if (m_second) begin
                m_second = 0;
                cpu_done = 1;
            end else if (ext_busy && (!FAIR || m_starve < MAXB)) begin
                exp_gnt = 1;
                exp_stall = cpu_busy;
                if (cpu_busy) m_starve++;
                nx_rvalid = !e_we;
                nx_rdata = ref_mem[e_addr[3:0]];
            end else if (cpu_busy && c_rd) begin
                exp_stall = 1;
                m_cpu_data = ref_mem[c_addr[3:0]];
                m_second = 1;
                m_starve = 0;
            end else begin
                cpu_done = 1;
                if (cpu_busy) m_starve = 0;
            end

            #1;
            chk("rnd_gnt", bus.ext_gnt, exp_gnt);
            chk("rnd_stall", bus.cpu_stall, exp_stall);
            chk("rnd_rvalid", bus.ext_rvalid, m_rvalid);
            if (m_rvalid) chk("rnd_ext_rdata", bus.ext_rdata, m_rdata);
            if (cpu_done && cpu_busy && c_rd) chk("rnd_cpu_rdata", bus.cpu_rdata, m_cpu_data);

            if (exp_gnt) begin
                if (e_we) ref_mem[e_addr[3:0]] = e_wd;
                ext_busy = 0;
            end else if (cpu_done && cpu_busy && c_wr) begin
                ref_mem[c_addr[3:0]] = c_wd;
            end
            m_rvalid = nx_rvalid;
            m_rdata = nx_rdata;
            if (cpu_done) cpu_busy = 0;
        end

        @(negedge clk);
        drive(0, 0, '0, '0, 0, 0, '0, '0);
        @(negedge clk);
        for (int a = 0; a < 16; a++) chk($sformatf("rnd_mem%0d", a), mem[a], ref_mem[a]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
